// File: rtl/cpa_serial_pkg.sv
`timescale 1ns/1ps
// cpa_serial_pkg
// Shared definitions for the serial carry-propagate adder: default operand
// width, slice width, derived slice count and product width, and the
// controller state encoding.
package cpa_serial_pkg;

  localparam int CPA_WIDTH      = 19;
  localparam int CPA_SLICE_W    = 5;
  localparam int CPA_NUM_SLICES = (CPA_WIDTH + CPA_SLICE_W - 1) / CPA_SLICE_W;
  localparam int CPA_PROD_W     = CPA_NUM_SLICES * CPA_SLICE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } cpa_state_e;

endpackage : cpa_serial_pkg

// File: rtl/cpa_slice.sv
`timescale 1ns/1ps
// cpa_slice
// Combinational SLICE_W-bit ripple adder with carry-in and carry-out. One
// instance is time-shared across all slices of the serial adder.
// Ports:
//   a, b  - slice operands
//   cin   - carry from the previous slice
//   sum   - slice sum
//   cout  - carry into the next slice
module cpa_slice #(
  parameter int SLICE_W = 5
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] total_s;

  // Widen by one bit so the carry-out falls out of the top of the sum.
  always_comb begin
    total_s = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
    sum     = total_s[SLICE_W-1:0];
    cout    = total_s[SLICE_W];
  end

endmodule : cpa_slice

// File: rtl/cpa_serial.sv
`timescale 1ns/1ps
// cpa_serial
// Serial carry-propagate adder that resolves the two carry-save rows of a
// multiplier compressor into a binary product, SLICE_W bits per cycle.
// Ports:
//   clk, rst            - clock (rising edge) and async active-high reset
//   in_valid / in_ready - operand handshake (accepted only in IDLE)
//   row0, row1          - carry-save rows, bit i = column i
//   out_valid/out_ready - result handshake (result presented in DONE)
//   product             - resolved row0+row1, zero-extended to whole slices
//   busy                - high while an operation is in ADD or DONE
module cpa_serial
  import cpa_serial_pkg::*;
#(
  parameter  int WIDTH      = CPA_WIDTH,
  parameter  int SLICE_W    = CPA_SLICE_W,
  localparam int NUM_SLICES = (WIDTH + SLICE_W - 1) / SLICE_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              row0,
  input  logic [WIDTH-1:0]              row1,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_SLICES*SLICE_W-1:0] product,
  output logic                          busy
);

  localparam int PROD_W = NUM_SLICES * SLICE_W;
  localparam int IDX_W  = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  cpa_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [PROD_W-1:0]   row0_q, row0_d;
  logic [PROD_W-1:0]   row1_q, row1_d;
  logic [PROD_W-1:0]   product_q, product_d;

  logic [SLICE_W-1:0]  slice_a;
  logic [SLICE_W-1:0]  slice_b;
  logic [SLICE_W-1:0]  slice_sum;
  logic                slice_cout;
  logic                last_slice;

  // Select the operand slices addressed by the current slice index.
  always_comb begin
    slice_a = {SLICE_W{1'b0}};
    slice_b = {SLICE_W{1'b0}};
    for (int k = 0; k < NUM_SLICES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        slice_a = row0_q[k*SLICE_W +: SLICE_W];
        slice_b = row1_q[k*SLICE_W +: SLICE_W];
      end else begin
        slice_a = slice_a;
        slice_b = slice_b;
      end
    end
  end

  cpa_slice #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign last_slice = (idx_q == IDX_W'(NUM_SLICES - 1));

  // Controller next state: latch operands, step through slices, hold result.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    row0_d    = row0_q;
    row1_d    = row1_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          row0_d  = PROD_W'(row0);
          row1_d  = PROD_W'(row1);
          idx_d   = {IDX_W{1'b0}};
          carry_d = 1'b0;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end

      ADD: begin
        // Only the current slice of product is written; higher slices keep
        // whatever the previous result left there until their turn.
        for (int k = 0; k < NUM_SLICES; k++) begin
          if (idx_q == IDX_W'(k)) begin
            product_d[k*SLICE_W +: SLICE_W] = slice_sum;
          end else begin
            product_d[k*SLICE_W +: SLICE_W] = product_d[k*SLICE_W +: SLICE_W];
          end
        end
        // The carry-out of the top slice is dropped; it is zero for rows
        // produced by a valid multiplier compressor.
        carry_d = slice_cout;
        if (last_slice) begin
          idx_d   = {IDX_W{1'b0}};
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ADD;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = {IDX_W{1'b0}};
        carry_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= {IDX_W{1'b0}};
      carry_q   <= 1'b0;
      row0_q    <= {PROD_W{1'b0}};
      row1_q    <= {PROD_W{1'b0}};
      product_q <= {PROD_W{1'b0}};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      row0_q    <= row0_d;
      row1_q    <= row1_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ADD) || (state_q == DONE);
  assign product   = product_q;

endmodule : cpa_serial

// File: tb/tb_cpa_serial.sv
`timescale 1ns/1ps
// tb_cpa_serial
// Directed self-checking bench for cpa_serial at default parameters.
module tb_cpa_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [18:0] row0 = 19'd0;
  logic [18:0] row1 = 19'd0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [19:0] product;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cpa_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .row0      (row0),
    .row1      (row1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accept one pair, measure latency to out_valid, check result, handshake.
  task automatic run_op(input string tag, input logic [18:0] a, input logic [18:0] b,
                        input logic [19:0] exp);
    int lat;
    @(negedge clk);
    row0 = a; row1 = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd4);
    check({tag, "_prod"}, 32'(product), 32'(exp));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ovld_low"}, 32'(out_valid), 32'd0);
    check({tag, "_irdy"}, 32'(in_ready), 32'd1);
  endtask

  logic [18:0] ra [8];
  logic [18:0] rb [8];
  logic [19:0] exp_q [$];
  logic [19:0] e;
  logic        pre;
  logic        seen;
  int          nacc, nout, cyc, last_cyc;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("zeros",  19'h00000, 19'h00000, 20'h00000);
    run_op("ripple", 19'h7FFFF, 19'h00001, 20'h80000);
    run_op("max",    19'h7FFFF, 19'h7F802, 20'hFF801);
    run_op("m512x3", 19'h00400, 19'h00200, 20'h00600);

    // Backpressure in DONE with a competing in_valid
    @(negedge clk);
    row0 = 19'h12345; row1 = 19'h01111; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("bp_ovld", 32'(out_valid), 32'd1);
    check("bp_prod", 32'(product), 32'h13456);
    for (int i = 0; i < 3; i++) begin
      row0 = 19'h00007; row1 = 19'h00009; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_hold_ovld", 32'(out_valid), 32'd1);
      check("bp_hold_prod", 32'(product), 32'h13456);
      check("bp_hold_irdy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_rel_ovld", 32'(out_valid), 32'd0);
    check("bp_rel_irdy", 32'(in_ready), 32'd1);
    check("bp_rel_prod", 32'(product), 32'h13456);
    run_op("after_bp", 19'h00400, 19'h00200, 20'h00600);

    // Reset during slice 2
    @(negedge clk);
    row0 = 19'h7FFFF; row1 = 19'h00001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_prod", 32'(product), 32'd0);
    check("mid_rst_irdy", 32'(in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("mid_no_ovld", 32'(seen), 32'd0);
    check("mid_prod_zero", 32'(product), 32'd0);
    run_op("post_rst", 19'h2AAAA, 19'h15556, 20'h40000);

    // Streaming with both handshakes held high
    for (int i = 0; i < 8; i++) begin
      ra[i] = 19'($urandom());
      rb[i] = 19'($urandom());
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    row0 = ra[0]; row1 = rb[0];
    pre = in_ready;
    nacc = 0; nout = 0; cyc = 0; last_cyc = 0;
    while (nout < 8 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (pre && in_valid) begin
        exp_q.push_back({1'b0, ra[nacc]} + {1'b0, rb[nacc]});
        nacc++;
        if (nacc < 8) begin
          row0 = ra[nacc]; row1 = rb[nacc];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 20'hFFFFF ^ product;
        check("stream_prod", 32'(product), 32'(e));
        if (nout > 0) check("stream_gap", 32'(cyc - last_cyc), 32'd6);
        last_cyc = cyc;
        nout++;
      end
      pre = in_ready;
    end
    check("stream_count", 32'(nout), 32'd8);
    out_ready = 1'b0;
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_cpa_serial

// File: doc/cpa_serial.md
CPA_SERIAL -- requirements
Module: cpa_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 19: number of carry-save columns consumed.
REQ-002 SHALL have parameter SLICE_W, default 5: bits resolved per add cycle.
REQ-003 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: row0/row1 carry an operand pair.
REQ-006 SHALL have port in_ready, output, 1: block can accept an operand pair.
REQ-007 SHALL have port row0, input, WIDTH: first carry-save row, bit i = column i, first bit.
REQ-008 SHALL have port row1, input, WIDTH: second carry-save row, bit i = column i, second bit; 0 for single-bit columns.
REQ-009 SHALL have port out_valid, output, 1: product holds a completed result.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts product.
REQ-011 SHALL have port product, output, NUM_SLICES*SLICE_W (20 at defaults): resolved sum row0+row1.
REQ-012 SHALL have port busy, output, 1: high in ADD or DONE.

Function
REQ-013 SHALL define NUM_SLICES = ceil(WIDTH/SLICE_W), which is 4 at defaults.
REQ-014 SHALL have FSM states IDLE, ADD, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 SHALL, on an edge with IDLE and in_valid high, latch row0/row1 zero-extended to NUM_SLICES*SLICE_W, clear the slice index and carry, and go to ADD.
REQ-016 SHALL, on each ADD edge for slice k, write product[k*SLICE_W +: SLICE_W] = row0 slice k + row1 slice k + carry, register the slice carry-out, and increment k.
REQ-017 SHALL go from ADD to DONE on the edge that processes slice NUM_SLICES-1.
REQ-018 Latency SHALL be NUM_SLICES edges from the accept edge to out_valid high (4 at defaults).
REQ-019 SHALL discard the carry-out of the last slice; for valid multiplier rows it is 0.
REQ-020 SHALL hold product and out_valid stable in DONE while out_ready is low.
REQ-021 SHALL go from DONE to IDLE on an edge with out_ready high; in_ready rises the following cycle, with no same-cycle bypass.
REQ-022 Back-to-back throughput with in_valid and out_ready held high SHALL be one result per NUM_SLICES+2 cycles.
REQ-023 SHALL ignore in_valid outside IDLE and leave latched operands unchanged.
REQ-024 SHALL NOT change product bits above the current slice during ADD; bits from a previous result may remain until overwritten.

Reset
REQ-025 rst high SHALL immediately force state IDLE, slice index 0, carry 0, product 0, and latched rows 0, so out_valid=0, busy=0, in_ready=1.
REQ-026 rst asserted mid-ADD or in DONE SHALL abort the operation with no output handshake; the first accept after rst falls starts clean.

Structure
REQ-027 Shared package SHALL hold WIDTH, SLICE_W, NUM_SLICES, the product width, and the state enum (IDLE/ADD/DONE).
REQ-028 SHALL contain one sub-module, cpa_slice: combinational SLICE_W-bit adder with carry-in and carry-out, instantiated once and reused each ADD cycle.
REQ-029 SHALL contain no multiplier or compressor logic; inputs are the two-row compressor outputs packed into row0/row1.

Verification
REQ-030 Zeros: row0=0, row1=0 -> out_valid 4 edges after accept, product=0x00000.
REQ-031 Full ripple: row0=0x7FFFF, row1=0x00001 -> product=0x80000, with the carry crossing every slice boundary.
REQ-032 Max product: rows from compressing a=1023, b=1023 -> product=0xFF801 (1046529); also check 512*3 -> 0x00600.
REQ-033 Backpressure: out_ready low 3 cycles in DONE -> product and out_valid stable, in_ready=0, a second in_valid ignored; release -> handshake, then IDLE.
REQ-034 Reset mid-op: rst pulse during slice 2 -> out_valid never rises, product=0, in_ready=1 next cycle; next operand pair resolves correctly.
REQ-035 Streaming: 8 random pairs with in_valid and out_ready held high -> each product = row0+row1, spaced exactly 6 cycles apart.
